// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Front-end sequencer for the pipelined MIPS core. Chooses the next PC value
// and its write enable, drives the IF/ID and ID/EX stall/flush/bubble
// controls and holds the instruction-memory request. It arbitrates between
// sequential fetch, jump/branch redirects, load-use stalls, multi-cycle MDU
// stalls and instruction-memory wait states.
//
// Build option:
//   FETCH_CTRL_MDU_EN  defined   -> MDU_WAIT state and its down-counter exist.
//                                   A mult/div in ID holds the next
//                                   instruction for MDU_CYCLES cycles.
//                      undefined -> mdu_start is ignored.
//
// Parameters:
//   RESET_VECTOR  first fetch address after reset
//   MDU_CYCLES    cycles the instruction behind a mult/div is held (1..255)
//
// Ports:
//   clk            core clock, rising edge
//   reset_n        asynchronous active-low reset
//   pc_current     current PC register value
//   branch_taken   branch resolved taken in ID
//   branch_target  branch destination
//   jump           J/JAL/JR in ID
//   jump_target    jump destination
//   id_ex_mem_read instruction in EX is a load
//   id_ex_rt       load destination register
//   if_id_rs/rt    source registers of the instruction in ID
//   mdu_start      instruction in ID is mult/div
//   imem_ready     instruction memory returns data this cycle
//   imem_req       fetch request at pc_current
//   pc_enable      PC write enable
//   pc_next        PC next value
//   if_id_enable   IF/ID register load enable
//   if_id_flush    load NOP into IF/ID
//   id_ex_bubble   load NOP into ID/EX
//   stall_count    saturating count of front-end stall cycles
//   state_dbg      current FSM state encoding
//                  (0 BOOT, 1 RUN, 2 REDIR_PEND, 3 MDU_WAIT)
//
// Handshake: imem_req is a level request for the word at pc_current. The
// fetch completes in the cycle where imem_req && imem_ready. pc_current
// stays stable until that cycle, and the PC only advances on the edge that
// ends it.
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned MDU_CYCLES   = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_current,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  id_ex_rt,
    input  logic [4:0]  if_id_rs,
    input  logic [4:0]  if_id_rt,
    input  logic        mdu_start,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic        pc_enable,
    output logic [31:0] pc_next,
    output logic        if_id_enable,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic [15:0] stall_count,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        RUN        = 2'd1,
        REDIR_PEND = 2'd2
`ifdef FETCH_CTRL_MDU_EN
        ,
        MDU_WAIT   = 2'd3
`endif
    } state_t;

    localparam logic [7:0] MDU_LOAD = 8'(MDU_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pend_target;
    logic [31:0] pend_nxt;
    logic [31:0] redir_target;
    logic        load_use;

`ifdef FETCH_CTRL_MDU_EN
    logic [7:0]  mdu_cnt;
    logic [7:0]  mdu_cnt_nxt;
`else
    logic        unused_mdu;
    assign unused_mdu = mdu_start ^ (^MDU_LOAD);
`endif

    // A load writing $0 never creates a real dependency.
    assign load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                      ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

    // Jump wins when both redirects fire; there is no delay slot.
    assign redir_target = jump ? jump_target : branch_target;

    assign state_dbg = state;

    always_comb begin
        imem_req     = 1'b1;
        pc_enable    = 1'b0;
        pc_next      = pc_current + 32'd4;
        if_id_enable = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        state_nxt    = state;
        pend_nxt     = pend_target;
`ifdef FETCH_CTRL_MDU_EN
        mdu_cnt_nxt  = mdu_cnt;
`endif

        case (state)
            BOOT: begin
                imem_req     = 1'b0;
                pc_next      = RESET_VECTOR;
                pc_enable    = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                state_nxt    = RUN;
            end

            RUN: begin
                if (load_use) begin
                    // Hold PC and IF/ID, insert one bubble. Redirects and
                    // mdu_start are ignored; they are seen again next cycle.
                    id_ex_bubble = 1'b1;
                end else if (jump || branch_taken) begin
                    if_id_enable = 1'b1;
                    if_id_flush  = 1'b1;
                    if (imem_ready) begin
                        pc_next   = redir_target;
                        pc_enable = 1'b1;
                    end else begin
                        // The current fetch has not completed yet. Park the
                        // target until memory accepts the PC change.
                        pend_nxt  = redir_target;
                        state_nxt = REDIR_PEND;
                    end
`ifdef FETCH_CTRL_MDU_EN
                end else if (mdu_start) begin
                    pc_enable    = imem_ready;
                    if_id_enable = 1'b1;
                    if_id_flush  = !imem_ready;
                    mdu_cnt_nxt  = MDU_LOAD;
                    state_nxt    = MDU_WAIT;
`endif
                end else begin
                    pc_enable    = imem_ready;
                    if_id_enable = 1'b1;
                    if_id_flush  = !imem_ready;
                end
            end

            REDIR_PEND: begin
                pc_next      = pend_target;
                pc_enable    = imem_ready;
                if_id_enable = 1'b1;
                if_id_flush  = 1'b1;
                if (imem_ready) begin
                    state_nxt = RUN;
                end
            end

`ifdef FETCH_CTRL_MDU_EN
            MDU_WAIT: begin
                // Counter runs MDU_LOAD..1, giving exactly MDU_CYCLES holds.
                id_ex_bubble = 1'b1;
                mdu_cnt_nxt  = mdu_cnt - 8'd1;
                if (mdu_cnt == 8'd1) begin
                    state_nxt = RUN;
                end
            end
`endif

            default: begin
                state_nxt = BOOT;
            end
        endcase

        // Reset forces safe outputs immediately, independent of the clock.
        if (!reset_n) begin
            imem_req     = 1'b0;
            pc_enable    = 1'b0;
            pc_next      = RESET_VECTOR;
            if_id_enable = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= BOOT;
            pend_target <= 32'h0000_0000;
            stall_count <= 16'h0000;
`ifdef FETCH_CTRL_MDU_EN
            mdu_cnt     <= 8'd0;
`endif
        end else begin
            state       <= state_nxt;
            pend_target <= pend_nxt;
`ifdef FETCH_CTRL_MDU_EN
            mdu_cnt     <= mdu_cnt_nxt;
`endif
            if ((state != BOOT) && !pc_enable && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Drives fetch_ctrl cycle by cycle. Inputs change on the falling edge. The
// expected output vector for each cycle is queued as the stimulus is applied
// and checked 2 ns later against the combinational outputs. A small PC
// register closes the loop from pc_next/pc_enable back to pc_current.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset_n;
    always #5 clk = ~clk;

    logic [31:0] pc_current;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rt;
    logic [4:0]  if_id_rs;
    logic [4:0]  if_id_rt;
    logic        mdu_start;
    logic        imem_ready;
    logic        imem_req;
    logic        pc_enable;
    logic [31:0] pc_next;
    logic        if_id_enable;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic [15:0] stall_count;
    logic [1:0]  state_dbg;

    fetch_ctrl #(
        .RESET_VECTOR (32'h0000_0000),
        .MDU_CYCLES   (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pc_current     (pc_current),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rt       (id_ex_rt),
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt),
        .mdu_start      (mdu_start),
        .imem_ready     (imem_ready),
        .imem_req       (imem_req),
        .pc_enable      (pc_enable),
        .pc_next        (pc_next),
        .if_id_enable   (if_id_enable),
        .if_id_flush    (if_id_flush),
        .id_ex_bubble   (id_ex_bubble),
        .stall_count    (stall_count),
        .state_dbg      (state_dbg)
    );

    // Core PC register fed by the DUT.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pc_current <= 32'h0000_0000;
        else if (pc_enable) pc_current <= pc_next;
    end

    // ---------------- scoreboard ----------------
    // Vector layout: {imem_req, pc_enable, pc_next[31:0], if_id_enable,
    //                 if_id_flush, id_ex_bubble}
    localparam int W = 37;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] msk_q[$];
    int total = 0;
    int bad   = 0;

    // Field masks {req, en, nxt, ide, flush, bub}
    localparam logic [5:0] M_ALL   = 6'b111111;
    localparam logic [5:0] M_STALL = 6'b110101;
    localparam logic [5:0] M_REDIR = 6'b111010;
    localparam logic [5:0] M_WAITR = 6'b110010;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic req, input logic en,
                                          input logic [31:0] nxt, input logic ide,
                                          input logic fl, input logic bub);
        return {req, en, nxt, ide, fl, bub};
    endfunction

    // Queue the expectation for the stimulus just applied, sample the DUT,
    // then move on to the next falling edge.
    task automatic run_cyc(input string tag, input logic req, input logic en,
                           input logic [31:0] nxt, input logic ide, input logic fl,
                           input logic bub, input logic [5:0] m);
        logic [W-1:0] e;
        logic [W-1:0] k;
        exp_q.push_back(pack(req, en, nxt, ide, fl, bub));
        msk_q.push_back({m[5], m[4], {32{m[3]}}, m[2], m[1], m[0]});
        #2;
        if (exp_q.size() == 0 || msk_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            k = msk_q.pop_front();
            check(tag, pack(imem_req, pc_enable, pc_next, if_id_enable,
                            if_id_flush, id_ex_bubble) & k, e & k);
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n        = 1'b0;
        branch_taken   = 1'b0;
        branch_target  = 32'h0;
        jump           = 1'b0;
        jump_target    = 32'h0;
        id_ex_mem_read = 1'b0;
        id_ex_rt       = 5'd0;
        if_id_rs       = 5'd0;
        if_id_rt       = 5'd0;
        mdu_start      = 1'b0;
        imem_ready     = 1'b1;

        @(negedge clk);
        run_cyc("reset_out", 0, 0, 32'h0, 0, 1, 1, M_ALL);
        check("reset_stall", stall_count, 16'h0);
        check("reset_state", state_dbg, 2'd0);

        // Release on a falling edge, then BOOT, then sequential 0,4,8,C.
        reset_n = 1'b1;
        run_cyc("boot", 0, 1, 32'h0, 0, 1, 0, M_REDIR);
        run_cyc("seq_0", 1, 1, 32'h4, 1, 0, 0, M_ALL);
        run_cyc("seq_4", 1, 1, 32'h8, 1, 0, 0, M_ALL);
        run_cyc("seq_8", 1, 1, 32'hC, 1, 0, 0, M_ALL);
        check("stall_seq", stall_count, 16'd0);

        // Load-use stall: exactly one cycle.
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
        run_cyc("lu_stall", 1, 0, 32'h0, 0, 0, 1, M_STALL);
        id_ex_mem_read = 1'b0; id_ex_rt = 5'd0; if_id_rs = 5'd0;
        run_cyc("lu_after", 1, 1, 32'h10, 1, 0, 0, M_ALL);
        // Load into $0 is not a hazard.
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0;
        run_cyc("lu_rt0", 1, 1, 32'h14, 1, 0, 0, M_ALL);
        id_ex_mem_read = 1'b0;
        check("stall_lu", stall_count, 16'd1);

        // Jump to 0x400 with three wait cycles of memory.
        jump = 1'b1; jump_target = 32'h400; imem_ready = 1'b0;
        run_cyc("jmp_wait", 1, 0, 32'h0, 0, 1, 0, M_WAITR);
        jump_target = 32'h800;  // a new redirect while pending is ignored
        run_cyc("pend_1", 1, 0, 32'h400, 0, 1, 0, M_REDIR);
        run_cyc("pend_2", 1, 0, 32'h400, 0, 1, 0, M_REDIR);
        imem_ready = 1'b1;
        run_cyc("pend_go", 1, 1, 32'h400, 0, 1, 0, M_REDIR);
        jump = 1'b0;
        check("stall_jmp", stall_count, 16'd4);

        // Branch together with a load-use hazard: stall first, then redirect.
        branch_taken = 1'b1; branch_target = 32'h200;
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd7; if_id_rt = 5'd7;
        run_cyc("br_lu", 1, 0, 32'h0, 0, 0, 1, M_STALL);
        id_ex_mem_read = 1'b0;
        run_cyc("br_go", 1, 1, 32'h200, 0, 1, 0, M_REDIR);

        // Jump has priority over branch.
        jump = 1'b1; jump_target = 32'h300; branch_target = 32'h500;
        run_cyc("jmp_pri", 1, 1, 32'h300, 0, 1, 0, M_REDIR);
        branch_taken = 1'b0; jump_target = 32'hFFFF_FFFC;
        run_cyc("jmp_top", 1, 1, 32'hFFFF_FFFC, 0, 1, 0, M_REDIR);
        jump = 1'b0;
        run_cyc("wrap", 1, 1, 32'h0, 1, 0, 0, M_ALL);

        // Memory wait on a sequential fetch.
        imem_ready = 1'b0;
        run_cyc("seq_wait", 1, 0, 32'h4, 1, 1, 0, M_ALL);
        imem_ready = 1'b1;
        run_cyc("seq_go", 1, 1, 32'h4, 1, 0, 0, M_ALL);
        check("stall_wait", stall_count, 16'd6);

        // MDU hold.
        mdu_start = 1'b1;
        run_cyc("mdu_go", 1, 1, 32'h8, 1, 0, 0, M_ALL);
        mdu_start = 1'b0;
`ifdef FETCH_CTRL_MDU_EN
        for (int i = 0; i < 4; i++) begin
            jump = (i == 1); jump_target = 32'h900;  // ignored during the hold
            run_cyc("mdu_hold", 1, 0, 32'h0, 0, 0, 1, M_STALL);
        end
        jump = 1'b0;
        run_cyc("mdu_done", 1, 1, 32'hC, 1, 0, 0, M_ALL);
        check("stall_mdu", stall_count, 16'd10);
`else
        run_cyc("mdu_off", 1, 1, 32'hC, 1, 0, 0, M_ALL);
        check("stall_mdu", stall_count, 16'd6);
`endif

        // Asynchronous reset in the middle of operation.
`ifdef FETCH_CTRL_MDU_EN
        mdu_start = 1'b1;
        run_cyc("mdu_go2", 1, 1, 32'h10, 1, 0, 0, M_ALL);
        mdu_start = 1'b0;
        run_cyc("mdu_hold2", 1, 0, 32'h0, 0, 0, 1, M_STALL);
`endif
        #2 reset_n = 1'b0;
        run_cyc("rst_mid", 0, 0, 32'h0, 0, 1, 1, M_ALL);
        check("rst_mid_stall", stall_count, 16'd0);
        check("rst_mid_state", state_dbg, 2'd0);
        reset_n = 1'b1;
        run_cyc("boot2", 0, 1, 32'h0, 0, 1, 0, M_REDIR);
        run_cyc("seq_after_rst", 1, 1, 32'h4, 1, 0, 0, M_ALL);
        run_cyc("seq_after_rst2", 1, 1, 32'h8, 1, 0, 0, M_ALL);
        check("stall_final", stall_count, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
